// File: rtl/wisc_pkg.sv
// Shared constants and types for the 16-bit pipeline front end.
// Holds opcodes, the NOP encoding, the fetch FSM state type and an HLT decode helper.
package wisc_pkg;

  localparam logic [3:0]  OP_HLT   = 4'b1111;
  localparam logic [3:0]  OP_B     = 4'b1100;
  localparam logic [3:0]  OP_BR    = 4'b1101;
  localparam logic [15:0] NOP_INST = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DISCARD,
    ST_HALTED
  } fetch_state_e;

  function automatic logic is_hlt(input logic [15:0] inst);
    return inst[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 1-cycle latency.
// en=0 holds the contents; bubble=1 loads a NOP with valid cleared.
module if_id_reg
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bubble,
  input  logic [15:0] inst_in,
  input  logic [15:0] pc_plus2_in,
  output logic [15:0] inst,
  output logic [15:0] pc_plus2,
  output logic        valid
);

  logic [15:0] inst_d, inst_q;
  logic [15:0] pc_plus2_d, pc_plus2_q;
  logic        valid_d, valid_q;

  always_comb begin
    inst_d     = inst_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (en) begin
      if (bubble) begin
        inst_d     = NOP_INST;
        pc_plus2_d = 16'h0000;
        valid_d    = 1'b0;
      end else begin
        inst_d     = inst_in;
        pc_plus2_d = pc_plus2_in;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q     <= NOP_INST;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      inst_q     <= inst_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign inst     = inst_q;
  assign pc_plus2 = pc_plus2_q;
  assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem requests, loads IF/ID one cycle after data returns.
// stall freezes PC and IF/ID; a miss holds imem_addr until imem_valid and inserts bubbles.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        IF_Flush,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] IF_ID_Inst,
  output logic [15:0] IF_ID_PC_plus2,
  output logic        IF_ID_Valid,
  output logic        halted
);

  fetch_state_e state_d, state_q;
  logic [15:0]  pc_d, pc_q;
  logic [15:0]  pend_d, pend_q;
  logic         req_d, req_q;
  logic         halted_d, halted_q;
  logic         ifid_en, ifid_bubble;
  logic [15:0]  pc_plus2, tgt;
  logic         flush_ok;

  assign pc_plus2 = pc_q + 16'd2;
  assign tgt      = {br_target[15:1], 1'b0};
  assign flush_ok = IF_Flush && !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    ifid_en     = 1'b1;
    ifid_bubble = 1'b1;
    case (state_q)
      ST_FETCH: begin
        if (stall) begin
          ifid_en = 1'b0;
        end else if (IF_Flush) begin
          if (imem_valid) begin
            pc_d = tgt;
          end else begin
            // access still in flight: keep the address stable, redirect once it lands
            pend_d  = tgt;
            state_d = ST_DISCARD;
          end
        end else if (imem_valid) begin
          ifid_bubble = 1'b0;
          if (is_hlt(imem_data)) state_d = ST_HALTED;
          else                   pc_d    = pc_plus2;
        end
      end
      ST_DISCARD: begin
        ifid_en = !stall;
        if (flush_ok) pend_d = tgt;
        if (imem_valid) begin
          pc_d    = flush_ok ? tgt : pend_q;
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        ifid_en = !stall;
        if (flush_ok) begin
          pc_d    = tgt;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    req_d    = (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= PC_RESET;
      pend_q   <= PC_RESET;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign halted    = halted_q;

  if_id_reg u_if_id (
    .clk         (clk),
    .rst         (rst),
    .en          (ifid_en),
    .bubble      (ifid_bubble),
    .inst_in     (imem_data),
    .pc_plus2_in (pc_plus2),
    .inst        (IF_ID_Inst),
    .pc_plus2    (IF_ID_PC_plus2),
    .valid       (IF_ID_Valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: per-cycle inputs with hand-computed address and IF/ID results.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, IF_Flush, imem_valid;
  logic [15:0] br_target, imem_data;
  logic        imem_req, IF_ID_Valid, halted;
  logic [15:0] imem_addr, IF_ID_Inst, IF_ID_PC_plus2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .IF_Flush       (IF_Flush),
    .br_target      (br_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_data      (imem_data),
    .IF_ID_Inst     (IF_ID_Inst),
    .IF_ID_PC_plus2 (IF_ID_PC_plus2),
    .IF_ID_Valid    (IF_ID_Valid),
    .halted         (halted)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] tgt;
    logic        vld;
    logic [15:0] dat;
    logic [15:0] e_addr;
    logic        e_req;
    logic [15:0] e_inst;
    logic [15:0] e_pc2;
    logic        e_v;
    logic        e_h;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic f, input logic [15:0] t, input logic v,
                     input logic [15:0] d, input logic [15:0] ea, input logic er,
                     input logic [15:0] ei, input logic [15:0] ep, input logic ev,
                     input logic eh);
    vec_t x;
    x.stall = s; x.flush = f; x.tgt = t; x.vld = v; x.dat = d;
    x.e_addr = ea; x.e_req = er; x.e_inst = ei; x.e_pc2 = ep; x.e_v = ev; x.e_h = eh;
    vq.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic [15:0] t, input logic v,
                       input logic [15:0] d);
    stall = s; IF_Flush = f; br_target = t; imem_valid = v; imem_data = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 16'hDEAD);

    // stall flush  tgt      vld data      addr     req inst      pc2      v  h
    add(0, 0, 16'h0000, 1, 16'h1111, 16'h0000, 1, 16'h1111, 16'h0002, 1, 0);
    add(0, 0, 16'h0000, 1, 16'h2222, 16'h0002, 1, 16'h2222, 16'h0004, 1, 0);
    add(0, 0, 16'h0000, 1, 16'h3333, 16'h0004, 1, 16'h3333, 16'h0006, 1, 0);
    add(0, 0, 16'h0000, 1, 16'h4444, 16'h0006, 1, 16'h4444, 16'h0008, 1, 0);
    add(0, 1, 16'h0041, 1, 16'h5555, 16'h0008, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 1, 16'h6666, 16'h0040, 1, 16'h6666, 16'h0042, 1, 0);
    add(1, 1, 16'h0100, 1, 16'h7777, 16'h0042, 1, 16'h6666, 16'h0042, 1, 0);
    add(1, 0, 16'h0000, 0, 16'hDEAD, 16'h0042, 1, 16'h6666, 16'h0042, 1, 0);
    add(0, 0, 16'h0000, 1, 16'h7777, 16'h0042, 1, 16'h7777, 16'h0044, 1, 0);
    add(0, 0, 16'h0000, 0, 16'hDEAD, 16'h0044, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 1, 16'h8888, 16'h0044, 1, 16'h8888, 16'h0046, 1, 0);
    // redirect to 0x10, then a 3-cycle miss with a flush to 0x100 in its first cycle
    add(0, 1, 16'h0010, 1, 16'hDEAD, 16'h0046, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0100, 0, 16'hDEAD, 16'h0010, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 0, 16'hDEAD, 16'h0010, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 1, 16'h9999, 16'h0010, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 1, 16'hA000, 16'h0100, 1, 16'hA000, 16'h0102, 1, 0);
    // HLT at 0x0008, then a wrong-path flush to 0x0020
    add(0, 1, 16'h0008, 1, 16'hDEAD, 16'h0102, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 1, 16'hF000, 16'h0008, 1, 16'hF000, 16'h000A, 1, 1);
    add(0, 0, 16'h0000, 0, 16'hDEAD, 16'h0008, 0, 16'h0000, 16'h0000, 0, 1);
    add(0, 0, 16'h0000, 0, 16'hDEAD, 16'h0008, 0, 16'h0000, 16'h0000, 0, 1);
    add(0, 1, 16'h0020, 0, 16'hDEAD, 16'h0008, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 1, 16'h1234, 16'h0020, 1, 16'h1234, 16'h0022, 1, 0);
    // PC wrap at 0xFFFE
    add(0, 1, 16'hFFFE, 1, 16'hDEAD, 16'h0022, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 16'h0000, 1, 16'h5678, 16'hFFFE, 1, 16'h5678, 16'h0000, 1, 0);
    add(0, 0, 16'h0000, 1, 16'h1357, 16'h0000, 1, 16'h1357, 16'h0002, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   -1, {15'b0, imem_req},    16'h0000);
    chk("rst_addr",  -1, imem_addr,            16'h0000);
    chk("rst_inst",  -1, IF_ID_Inst,           16'h0000);
    chk("rst_valid", -1, {15'b0, IF_ID_Valid}, 16'h0000);
    chk("rst_halt",  -1, {15'b0, halted},      16'h0000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].stall, vq[i].flush, vq[i].tgt, vq[i].vld, vq[i].dat);
      #1;
      chk("addr", i, imem_addr, vq[i].e_addr);
      chk("req",  i, {15'b0, imem_req}, {15'b0, vq[i].e_req});
      @(posedge clk);
      #1;
      chk("inst",   i, IF_ID_Inst, vq[i].e_inst);
      chk("pc2",    i, IF_ID_PC_plus2, vq[i].e_pc2);
      chk("valid",  i, {15'b0, IF_ID_Valid}, {15'b0, vq[i].e_v});
      chk("halted", i, {15'b0, halted}, {15'b0, vq[i].e_h});
    end

    // Reset asserted while in DISCARD: state, PC and IF/ID must clear at once
    @(negedge clk);
    drive(0, 1, 16'h0030, 1, 16'hDEAD);
    @(negedge clk);
    #1;
    chk("pre_disc_addr", 100, imem_addr, 16'h0030);
    drive(0, 1, 16'h0200, 0, 16'hDEAD);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 16'h0000, 0, 16'hDEAD);
    #1;
    chk("disc_addr_hold", 101, imem_addr, 16'h0030);
    rst = 1'b1;
    #1;
    chk("mid_rst_addr",  102, imem_addr, 16'h0000);
    chk("mid_rst_req",   102, {15'b0, imem_req}, 16'h0000);
    chk("mid_rst_valid", 102, {15'b0, IF_ID_Valid}, 16'h0000);
    chk("mid_rst_inst",  102, IF_ID_Inst, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 0, 16'h0000, 1, 16'h4321);
    #1;
    chk("post_rst_addr", 103, imem_addr, 16'h0000);
    chk("post_rst_req",  103, {15'b0, imem_req}, 16'h0001);
    @(posedge clk);
    #1;
    chk("post_rst_inst", 103, IF_ID_Inst, 16'h4321);
    chk("post_rst_pc2",  103, IF_ID_PC_plus2, 16'h0002);
    chk("post_rst_vld",  103, {15'b0, IF_ID_Valid}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined processor: owns the PC, drives the instruction-memory request, and loads the IF/ID pipeline register consumed by decode and the hazard detection unit. It honours the HDU's `stall` and `IF_Flush`, redirects to the branch target resolved in ID, stops fetching on HLT, and tolerates multi-cycle instruction memory (cache misses) via a request/valid handshake.

## Interface
- `PC_RESET`, 16'h0000, PC value after reset
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  from HDU; hold PC and IF/ID
- `IF_Flush`  in  1  from HDU; taken branch in ID, squash IF
- `br_target`  in  16  branch target computed in ID, valid with `IF_Flush`
- `imem_req`  out  1  instruction read request
- `imem_addr`  out  16  fetch address
- `imem_valid`  in  1  read data valid this cycle
- `imem_data`  in  16  instruction word
- `IF_ID_Inst`  out  16  registered instruction (NOP on bubble)
- `IF_ID_PC_plus2`  out  16  registered PC+2 of that instruction
- `IF_ID_Valid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  HLT fetched, fetch stopped

## Operation
- States: FETCH, DISCARD, HALTED.
- FETCH: `imem_req`=1, `imem_addr`=PC. Priority per cycle: `stall` > `IF_Flush` > memory.
  - `stall`=1: PC, IF/ID, state unchanged; `IF_Flush` ignored; returned data dropped and re-requested (address unchanged).
  - `IF_Flush`=1, `imem_valid`=1: PC←`br_target`, IF/ID←bubble.
  - `IF_Flush`=1, `imem_valid`=0: pending target latched, IF/ID←bubble, → DISCARD (address held stable for the in-flight access).
  - `imem_valid`=1, no flush: IF/ID←{`imem_data`, PC+2, valid 1}; PC←PC+2; if opcode `imem_data[15:12]`=4'b1111 (HLT): PC not advanced, → HALTED.
  - `imem_valid`=0: IF/ID←bubble, PC held.
- DISCARD: `imem_addr`=old PC until `imem_valid`; returned data dropped; then PC←pending target, → FETCH. `stall` holds IF/ID only. A second `IF_Flush` overwrites the pending target.
- HALTED: `imem_req`=0, `halted`=1, IF/ID loads bubbles once HLT leaves (unless `stall`). `IF_Flush` (HLT was wrong-path) → PC←`br_target`, `halted`=0, → FETCH.
- Bubble = {`NOP_INST`, 16'h0000, valid 0}.
- PC arithmetic 16-bit, wraps 16'hFFFE→16'h0000; bit 0 of `br_target` ignored (forced 0).

## Timing
- Reset (async): PC=`PC_RESET`, state FETCH, IF/ID=bubble, `halted`=0, `imem_req`=0 while `rst`=1, 1 from first cycle after.
- Zero-wait memory (`imem_valid` same cycle as request): one instruction per cycle into IF/ID.
- Taken branch: `IF_Flush` in cycle N → edge N+1 IF/ID bubble, PC=target → edge N+2 target instruction in IF/ID (one bubble).
- Memory latency L cycles: L-1 bubbles per fetch.
- `imem_addr` must not change while `imem_req`=1 and `imem_valid`=0.
- `stall` and `IF_Flush` are combinational from ID; sampled on the same edge as `imem_valid`.

## Structure
- Shared package `wisc_pkg`: opcode constants (`OP_HLT`=4'b1111, `OP_B`=4'b1100, `OP_BR`=4'b1101), `NOP_INST`=16'h0000, fetch state enum.
- Sub-module `if_id_reg`: IF/ID register with async reset, enable (~`stall`) and bubble-insert (flush/no-data) inputs.
- Top holds PC, pending-target register, FSM.

## Test plan
- Reset mid-run: assert `rst` while in DISCARD → PC=0, IF/ID bubble, state FETCH same cycle; first fetch at addr 0 after release.
- Zero-wait stream at 0x0000..0x0006 → IF_ID_PC_plus2 = 2,4,6,8 on consecutive edges, Valid=1.
- `IF_Flush` with `br_target`=0x0040 in cycle N → N+1 bubble, N+2 IF_ID_PC_plus2=0x0042; `stall`+`IF_Flush` together → no change.
- 3-cycle memory, `IF_Flush` to 0x0100 during miss at 0x0010 → addr held 0x0010 until valid, data dropped, next request 0x0100.
- HLT (0xF000) at 0x0008 → `halted`=1, `imem_req`=0, PC stays 0x0008; later `IF_Flush` to 0x0020 → resumes fetch at 0x0020.
- PC wrap: fetch at 0xFFFE → next addr 0x0000.
